ram_dxw_rwrw_be_clr: RTL and testbench
======================================

RAM_DXW_RWRW_BE_CLR -- requirements
Module: ram_dxw_rwrw_be_clr

Interface
REQ-001 Parameter DEPTH, default 256, number of words; SHALL be a power of two, at least 4.
REQ-002 Parameter WIDTH, default 32, word width; SHALL be a multiple of BYTE_W.
REQ-003 Parameter BYTE_W, default 8, byte-lane width; NBYTES = WIDTH/BYTE_W.
REQ-004 Parameter OUT_REG, default 0; 0 gives read latency 1, 1 gives read latency 2.
REQ-005 Parameter RDW_MODE, default 0; 0 returns old data on a same-port read-during-write, 1 returns new data.
REQ-006 Parameter CLEAR_ON_RESET, default 1; 1 starts a clear sweep after reset release.
REQ-007 One clock, clock; reset is asynchronous and active-low, reset_.
REQ-008 clock  input  1  rising-edge clock for all state.
REQ-009 reset_  input  1  asynchronous active-low reset.
REQ-010 clear_req  input  1  one-cycle pulse that starts a clear sweep.
REQ-011 busy  output  1  high while the clear sweep runs.
REQ-012 address_a / address_b  input  $clog2(DEPTH)  word address for the port.
REQ-013 wren_a / wren_b  input  1  write enable for the port.
REQ-014 byteena_a / byteena_b  input  NBYTES  per-lane write mask.
REQ-015 data_a / data_b  input  WIDTH  write data for the port.
REQ-016 q_a / q_b  output  WIDTH  read data for the port.
REQ-017 collision  output  1  one-cycle pulse flagging a write-write conflict.

Function
REQ-018 Each port SHALL read every cycle; q_x SHALL present mem[address_x] 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) after address capture.
REQ-019 A write SHALL update only the lanes whose byteena bit is 1; byteena=0 with wren=1 SHALL leave the memory unchanged.
REQ-020 For a same-port read-during-write, q SHALL be the pre-write word when RDW_MODE=0, and the byte-merged post-write word when RDW_MODE=1.
REQ-021 A cross-port read of an address written in the same cycle SHALL return the pre-write word.
REQ-022 When both ports write the same address in one cycle, each overlapping lane SHALL take port A's data; non-overlapping enabled lanes SHALL take their own port's data.
REQ-023 collision SHALL pulse high in the cycle after any overlapping lane is written by both ports at the same address.
REQ-024 The clear FSM SHALL have states IDLE and CLEAR: IDLE to CLEAR on clear_req, or on the first cycle after reset release when CLEAR_ON_RESET=1; CLEAR to IDLE after address DEPTH-1 is written.
REQ-025 CLEAR SHALL write all-zero data to all lanes of one address per cycle, ascending from 0, taking exactly DEPTH cycles with busy high.
REQ-026 During CLEAR, port writes SHALL be dropped, q_a/q_b SHALL be 0, collision SHALL stay 0, and clear_req SHALL be ignored.
REQ-027 A clear_req arriving in the same cycle as the last CLEAR write SHALL be ignored.
REQ-028 The sweep address counter SHALL stop at DEPTH-1 and SHALL NOT wrap.

Reset
REQ-029 While reset_ is low: FSM in IDLE, busy=0, q_a=q_b=0 (including the pipeline stage), collision=0, sweep counter=0.
REQ-030 Reset SHALL NOT initialise the memory array; asserting reset_ during CLEAR SHALL abort the sweep, and a new sweep SHALL start after release only when CLEAR_ON_RESET=1.

Structure
REQ-031 Package ram_pkg SHALL hold the RDW_OLD/RDW_NEW constants and the clear-FSM state enum.
REQ-032 Sub-module ram_clear_ctrl SHALL hold the FSM and sweep counter and SHALL drive busy and the clear address.
REQ-033 The array SHALL be a per-lane inferable memory with no reset, in the form vendor RAM inference requires.

Verification
REQ-034 DEPTH=256, WIDTH=32, CLEAR_ON_RESET=1: release reset -> busy high for exactly 256 cycles; then every read of addresses 0..255 returns 0.
REQ-035 Write A addr 5 data 0x11223344 byteena 4'b1111, then B writes addr 5 data 0xAABBCCDD byteena 4'b0011 -> read returns 0x1122CCDD after the stated latency, for OUT_REG=0 and OUT_REG=1.
REQ-036 A and B write addr 9 in one cycle, A 0x000000FF byteena 0001, B 0x0000FF00 byteena 0011 -> mem 0x0000FFFF, collision pulses once.
REQ-037 Port A holds 0xCAFE0000 at addr 3, then writes 0x0000BEEF to addr 3 while reading it -> q_a = 0xCAFE0000 (RDW_MODE=0) or 0x0000BEEF (RDW_MODE=1); a same-cycle port-B read returns 0xCAFE0000.
REQ-038 clear_req pulsed, then reset_ asserted at sweep cycle 100 -> busy, q_a, q_b fall to 0 asynchronously; with CLEAR_ON_RESET=0, busy stays 0 after release.
REQ-039 Port writes issued while busy=1 -> memory still all-zero after the sweep; collision stays 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and clear-FSM state type for the byte-enabled true-dual-port RAM.
// Read-during-write selectors are compared against the RDW_MODE parameter of the top.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear-sweep controller: walks addresses 0..DEPTH-1, one per cycle, while busy is high.
// Requests during a sweep are ignored; reset aborts the sweep and optionally restarts it.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1,
  parameter int AW             = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state;
  clr_state_t    state_nxt;
  logic          start_pend;
  logic [AW-1:0] cnt;

  // start_pend marks the first clock after reset release
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state      <= ST_IDLE;
      start_pend <= (CLEAR_ON_RESET != 0);
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      start_pend <= 1'b0;
      if (state == ST_IDLE) begin
        cnt <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clear_req || start_pend) state_nxt = ST_CLEAR;
      ST_CLEAR: if (cnt == LAST)             state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_CLEAR);
    clr_we   = (state == ST_CLEAR);
    clr_addr = cnt;
  end

endmodule

// File: rtl/ram_dxw_rwrw_be_clr.sv
// True dual-port byte-enabled RAM with hardware clear sweep; read latency 1 (OUT_REG=0) or 2.
// No backpressure: port writes are dropped and reads return zero while the sweep runs.
module ram_dxw_rwrw_be_clr
  import ram_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int WIDTH          = 32,
  parameter int BYTE_W         = 8,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1,
  parameter int NBYTES         = WIDTH / BYTE_W,
  parameter int AW             = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              clear_req,
  output logic              busy,
  input  logic [AW-1:0]     address_a,
  input  logic              wren_a,
  input  logic [NBYTES-1:0] byteena_a,
  input  logic [WIDTH-1:0]  data_a,
  output logic [WIDTH-1:0]  q_a,
  input  logic [AW-1:0]     address_b,
  input  logic              wren_b,
  input  logic [NBYTES-1:0] byteena_b,
  input  logic [WIDTH-1:0]  data_b,
  output logic [WIDTH-1:0]  q_b,
  output logic              collision
);

  logic              clr_we;
  logic [AW-1:0]     clr_addr;
  logic [NBYTES-1:0] lane_we_a;
  logic [NBYTES-1:0] lane_we_b;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;
  logic [WIDTH-1:0]  q_a_s;
  logic [WIDTH-1:0]  q_b_s;
  logic              coll_d;

  ram_clear_ctrl #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (AW)
  ) u_clear_ctrl (
    .clock     (clock),
    .reset_    (reset_),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign lane_we_a = (wren_a && !busy) ? byteena_a : '0;
  assign lane_we_b = (wren_b && !busy) ? byteena_b : '0;

  // One narrow array per lane keeps each write a full-word write for RAM inference.
  for (genvar l = 0; l < NBYTES; l++) begin : g_lane
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] rd_a_l;
    logic [BYTE_W-1:0] rd_b_l;

    // Port A is written last so it owns any lane both ports hit at one address.
    always_ff @(posedge clock) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else begin
        if (lane_we_b[l]) mem[address_b] <= data_b[l*BYTE_W +: BYTE_W];
        if (lane_we_a[l]) mem[address_a] <= data_a[l*BYTE_W +: BYTE_W];
      end
    end

    always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
        rd_a_l <= '0;
        rd_b_l <= '0;
      end else if (busy) begin
        rd_a_l <= '0;
        rd_b_l <= '0;
      end else begin
        rd_a_l <= (RDW_MODE == RDW_NEW && lane_we_a[l]) ? data_a[l*BYTE_W +: BYTE_W]
                                                        : mem[address_a];
        rd_b_l <= (RDW_MODE == RDW_NEW && lane_we_b[l]) ? data_b[l*BYTE_W +: BYTE_W]
                                                        : mem[address_b];
      end
    end

    assign rd_a[l*BYTE_W +: BYTE_W] = rd_a_l;
    assign rd_b[l*BYTE_W +: BYTE_W] = rd_b_l;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] pipe_a;
    logic [WIDTH-1:0] pipe_b;

    always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
        pipe_a <= '0;
        pipe_b <= '0;
      end else if (busy) begin
        pipe_a <= '0;
        pipe_b <= '0;
      end else begin
        pipe_a <= rd_a;
        pipe_b <= rd_b;
      end
    end

    assign q_a_s = pipe_a;
    assign q_b_s = pipe_b;
  end else begin : g_noreg
    assign q_a_s = rd_a;
    assign q_b_s = rd_b;
  end

  // Forcing zero here covers the first sweep cycle, before the read registers flush.
  assign q_a = busy ? '0 : q_a_s;
  assign q_b = busy ? '0 : q_b_s;

  assign coll_d = wren_a && wren_b && !busy && (address_a == address_b)
                  && (|(byteena_a & byteena_b));

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      collision <= 1'b0;
    end else begin
      collision <= coll_d;
    end
  end

endmodule

// File: tb/tb_ram_dxw_rwrw_be_clr.sv
// Bench: two instances (latency 1 / old-data, latency 2 / new-data without reset clear) on shared stimulus.
// Read expectations are queued when the address is driven and retired when the data is due.
module tb_ram_dxw_rwrw_be_clr;

  logic        clock = 1'b0;
  logic        reset_;
  logic        clear_req;
  logic [7:0]  address_a, address_b;
  logic        wren_a, wren_b;
  logic [3:0]  byteena_a, byteena_b;
  logic [31:0] data_a, data_b;

  logic        busy0, busy1, coll0, coll1;
  logic [31:0] q_a0, q_b0, q_a1, q_b1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    int          dut;
    int          port;
    logic [7:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ram_dxw_rwrw_be_clr #(
    .DEPTH(256), .WIDTH(32), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clock(clock), .reset_(reset_), .clear_req(clear_req), .busy(busy0),
    .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a), .q_a(q_a0),
    .address_b(address_b), .wren_b(wren_b), .byteena_b(byteena_b), .data_b(data_b), .q_b(q_b0),
    .collision(coll0)
  );

  ram_dxw_rwrw_be_clr #(
    .DEPTH(256), .WIDTH(32), .BYTE_W(8), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(0)
  ) dut1 (
    .clock(clock), .reset_(reset_), .clear_req(clear_req), .busy(busy1),
    .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a), .q_a(q_a1),
    .address_b(address_b), .wren_b(wren_b), .byteena_b(byteena_b), .data_b(data_b), .q_b(q_b1),
    .collision(coll1)
  );

  function automatic logic [31:0] obs(input int d, input int p);
    if (d == 0) return (p == 0) ? q_a0 : q_b0;
    return (p == 0) ? q_a1 : q_b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [31:0] o;
        o = obs(sb[i].dut, sb[i].port);
        checks++;
        assert (sb[i].due == cyc && o === sb[i].val) else begin
          errors++;
          $error("FAIL rd_d%0d_p%0d addr=%0d observed=%h expected=%h",
                 sb[i].dut, sb[i].port, sb[i].addr, o, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  // dut0 data is due one edge after capture, dut1 two edges after.
  task automatic expect_q(input int d, input int p, input logic [7:0] a, input logic [31:0] v);
    exp_t e;
    e.due  = cyc + 1 + d;
    e.dut  = d;
    e.port = p;
    e.addr = a;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clock);
    check_due();
  endtask

  task automatic op(input logic [7:0] aa, input logic wa, input logic [3:0] bea, input logic [31:0] da,
                    input logic [7:0] ab, input logic wb, input logic [3:0] beb, input logic [31:0] db);
    tick();
    address_a = aa; wren_a = wa; byteena_a = bea; data_a = da;
    address_b = ab; wren_b = wb; byteena_b = beb; data_b = db;
  endtask

  task automatic idle(input int n);
    repeat (n) op(8'd0, 1'b0, 4'h0, 32'd0, 8'd0, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic rd(input logic [7:0] aa, input logic [7:0] ab, input logic [31:0] ea, input logic [31:0] eb);
    op(aa, 1'b0, 4'h0, 32'd0, ab, 1'b0, 4'h0, 32'd0);
    expect_q(0, 0, aa, ea);
    expect_q(1, 0, aa, ea);
    expect_q(0, 1, ab, eb);
    expect_q(1, 1, ab, eb);
  endtask

  initial begin
    int n0, n1, w;
    logic wr;
    reset_ = 1'b0; clear_req = 1'b0;
    address_a = '0; wren_a = 1'b0; byteena_a = '0; data_a = '0;
    address_b = '0; wren_b = 1'b0; byteena_b = '0; data_b = '0;

    repeat (3) tick();
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_qa0", q_a0, 32'd0);
    chk("rst_qb0", q_b0, 32'd0);
    chk("rst_qa1", q_a1, 32'd0);
    chk("rst_qb1", q_b1, 32'd0);
    chk("rst_coll0", 32'(coll0), 32'd0);
    chk("rst_coll1", 32'(coll1), 32'd0);

    // dut0 sweeps on release; dut1 is launched by the simultaneous clear_req.
    tick();
    reset_ = 1'b1; clear_req = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 300; i++) begin
      wr = (i >= 10 && i < 200);
      op(8'(i), wr, 4'hF, 32'hDEAD0000 | i, 8'(i), wr, 4'hF, 32'hBEEF0000 | i);
      clear_req = 1'b0;
      if (busy0) n0++;
      if (busy1) n1++;
      if (busy0) chk("sweep_qa0", q_a0, 32'd0);
      if (busy1) chk("sweep_qb1", q_b1, 32'd0);
      chk("sweep_coll0", 32'(coll0), 32'd0);
      chk("sweep_coll1", 32'(coll1), 32'd0);
    end
    chk("busy_cycles_d0", n0, 32'd256);
    chk("busy_cycles_d1", n1, 32'd256);

    for (int i = 0; i < 256; i++) rd(8'(i), 8'(255 - i), 32'd0, 32'd0);

    // byte-lane merge across ports
    op(8'd5, 1'b1, 4'hF, 32'h11223344, 8'd0, 1'b0, 4'h0, 32'd0);
    op(8'd0, 1'b0, 4'h0, 32'd0, 8'd5, 1'b1, 4'h3, 32'hAABBCCDD);
    rd(8'd5, 8'd5, 32'h1122CCDD, 32'h1122CCDD);

    // same-address write-write with one overlapping lane
    op(8'd9, 1'b1, 4'h1, 32'h000000FF, 8'd9, 1'b1, 4'h3, 32'h0000FF00);
    rd(8'd9, 8'd9, 32'h0000FFFF, 32'h0000FFFF);
    chk("coll0_pulse", 32'(coll0), 32'd1);
    chk("coll1_pulse", 32'(coll1), 32'd1);
    rd(8'd9, 8'd9, 32'h0000FFFF, 32'h0000FFFF);
    chk("coll0_drop", 32'(coll0), 32'd0);
    chk("coll1_drop", 32'(coll1), 32'd0);

    // same address, disjoint lanes: no collision
    op(8'd30, 1'b1, 4'h3, 32'hAAAA5566, 8'd30, 1'b1, 4'hC, 32'h7788BBBB);
    rd(8'd30, 8'd30, 32'h77885566, 32'h77885566);
    chk("coll0_disjoint", 32'(coll0), 32'd0);

    // same-port read-during-write
    op(8'd3, 1'b1, 4'hF, 32'hCAFE0000, 8'd0, 1'b0, 4'h0, 32'd0);
    op(8'd3, 1'b1, 4'hF, 32'h0000BEEF, 8'd3, 1'b0, 4'h0, 32'd0);
    expect_q(0, 0, 8'd3, 32'hCAFE0000);
    expect_q(1, 0, 8'd3, 32'h0000BEEF);
    expect_q(0, 1, 8'd3, 32'hCAFE0000);
    expect_q(1, 1, 8'd3, 32'hCAFE0000);
    rd(8'd3, 8'd3, 32'h0000BEEF, 32'h0000BEEF);

    // wren with empty byteena leaves the word alone
    op(8'd3, 1'b1, 4'h0, 32'hFFFFFFFF, 8'd0, 1'b0, 4'h0, 32'd0);
    expect_q(0, 0, 8'd3, 32'h0000BEEF);
    expect_q(1, 0, 8'd3, 32'h0000BEEF);
    rd(8'd3, 8'd3, 32'h0000BEEF, 32'h0000BEEF);

    // partial-lane read-during-write returns the merged word in new-data mode
    op(8'd3, 1'b1, 4'h1, 32'h000000AA, 8'd0, 1'b0, 4'h0, 32'd0);
    expect_q(0, 0, 8'd3, 32'h0000BEEF);
    expect_q(1, 0, 8'd3, 32'h0000BEAA);
    rd(8'd3, 8'd3, 32'h0000BEAA, 32'h0000BEAA);

    // cross-port read of an address being written
    op(8'd20, 1'b0, 4'h0, 32'd0, 8'd20, 1'b1, 4'hF, 32'h12345678);
    expect_q(0, 0, 8'd20, 32'd0);
    expect_q(1, 0, 8'd20, 32'd0);
    expect_q(0, 1, 8'd20, 32'd0);
    expect_q(1, 1, 8'd20, 32'h12345678);
    rd(8'd20, 8'd20, 32'h12345678, 32'h12345678);
    idle(4);

    // reset in the middle of a requested sweep
    idle(1);
    clear_req = 1'b1;
    idle(1);
    clear_req = 1'b0;
    idle(99);
    chk("mid_sweep_busy0", 32'(busy0), 32'd1);
    chk("mid_sweep_busy1", 32'(busy1), 32'd1);
    #2 reset_ = 1'b0;
    #1;
    chk("abort_busy0", 32'(busy0), 32'd0);
    chk("abort_busy1", 32'(busy1), 32'd0);
    chk("abort_qa0", q_a0, 32'd0);
    chk("abort_qb0", q_b0, 32'd0);
    chk("abort_qa1", q_a1, 32'd0);
    chk("abort_qb1", q_b1, 32'd0);
    tick();
    tick();
    reset_ = 1'b1;
    idle(3);
    chk("no_restart_busy1", 32'(busy1), 32'd0);
    chk("restart_busy0", 32'(busy0), 32'd1);
    w = 0;
    while (busy0 && w < 400) begin
      idle(1);
      w++;
    end
    chk("restart_done_busy0", 32'(busy0), 32'd0);
    rd(8'd9, 8'd5, 32'd0, 32'd0);
    rd(8'd3, 8'd20, 32'd0, 32'd0);
    idle(4);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
